bg_pixel_shifter: RTL and testbench
===================================

Name: bg_pixel_shifter

Overview:
- Consumer end of the background fetcher's FIFO push interface: holds fetched BG/window pixels and shifts them out to the LCD, at most one pixel per mode-3 dot.
- Discards the first SCX[2:0] pixels of each line for fine scroll, maps colour indices through BGP and tracks screen X.
- Raises line_done after 160 pixels have been emitted.
- Drives the fetcher's bg_fifo_full / bg_fifo_empty inputs; sits between the fetcher and the sprite mixer / LCD output.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 8.
- LINE_W, 160: visible pixels per scanline.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; single clock domain
- dot_en  in  1  PPU is in mode 3; pops and discards only occur in cycles with dot_en=1
- line_start  in  1  one-cycle pulse at mode-3 entry
- flush  in  1  clear FIFO contents (window start); same pulse as the fetcher's flush
- pop_stall  in  1  hold shifting (sprite fetch in progress)
- scx_fine  in  3  SCX[2:0], sampled on line_start
- bgp  in  8  BG palette register
- bg_enable  in  1  LCDC[0]
- push_en  in  1  fetcher pushes push_px this cycle
- push_px  in  ppu_pixel_t  pixel from the fetcher; only .color and .valid are used
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy
- pix_valid  out  1  pix_* outputs carry a pixel this cycle
- pix_idx  out  2  raw colour index (0 if bg_enable=0), for sprite priority
- pix_shade  out  2  BGP-mapped shade
- pix_x  out  8  screen X of the pixel on pix_*
- line_done  out  1  one-cycle pulse when pixel LINE_W-1 is emitted
- overflow  out  1  sticky: a push arrived while full

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State IDLE; FIFO empty; count=0; fifo_empty=1; fifo_full=0.
  - pix_valid=0, pix_idx=0, pix_shade=0, pix_x=0, line_done=0, overflow=0.
  - Reset mid-line discards all state; no line_done is issued.
- FIFO is a circular buffer with wr_ptr/rd_ptr wrapping modulo DEPTH.
  - A pixel pushed in cycle t is poppable no earlier than t+1; there is no bypass.
- Push: accepted in any state and regardless of dot_en whenever push_en=1 and the FIFO is not full.
  - Push while full: pixel dropped, overflow<=1, FIFO unchanged.
- Pop condition: dot_en && !pop_stall && !fifo_empty && state ∈ {DISCARD, SHIFT}.
- Simultaneous push and pop: both take effect. count is unchanged. The full check uses pre-pop occupancy, so a push while full is dropped even if a pop occurs in the same cycle.
- States:
  - IDLE: no pops. line_start → DISCARD with disc_cnt=scx_fine if scx_fine≠0, else → SHIFT.
  - DISCARD: each pop decrements disc_cnt; the popped pixel is not emitted and pix_x does not advance. The pop that brings disc_cnt to 0 → SHIFT.
  - SHIFT: each pop emits the pixel.
    - Next cycle: pix_valid=1; pix_idx = bg_enable ? px.color : 0; pix_shade = bgp[2*pix_idx+1 -: 2].
    - pix_x is the current X; the X counter then increments.
    - When the emitted X == LINE_W-1: line_done=1 in the same cycle as that pixel's pix_valid, and → DONE.
  - DONE: no pops; pushes are still accepted. line_start → as from IDLE.
- line_start, from any state:
  - Empty the FIFO.
  - Clear the X counter.
  - Reload disc_cnt from scx_fine.
  - A push in the same cycle is dropped.
- flush:
  - Empty the FIFO; a push in the same cycle is dropped.
  - pix_x and state are preserved, except DISCARD → SHIFT (fine-scroll discard abandoned).
  - line_start takes priority over flush.
- pix_valid is 0 in every cycle that does not follow an emitting pop; pix_idx, pix_shade and pix_x hold their last values.
- Latency: pop at edge t → pix_* valid during cycle t+1 (one register stage).
- Width rules: the X counter is 8-bit and never exceeds LINE_W-1; disc_cnt is 3-bit.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with push_en=1 → count=0, fifo_empty=1, pix_valid=0, overflow=0. After release, IDLE: pushes accumulate, no pix_valid until line_start.
2. Fine scroll: scx_fine=3, line_start, push 8 pixels colour 0,1,2,3,0,1,2,3, bgp=8'hE4, dot_en=1 → first 3 pixels discarded; emitted pix_idx=3,0,1,2,3 with pix_x=0..4 and pix_shade equal to pix_idx.
3. Simultaneous push/pop: count=5 in SHIFT, push_en=1 with a pop → count stays 5. Fill to 16, push again → dropped, overflow=1, fifo_full=1.
4. Line end: scx_fine=0, feed 160+8 pixels → line_done pulses exactly once, with pix_x=159. No further pix_valid; the remaining pixels stay in the FIFO until the next line_start empties it.
5. Flush and stall: flush at pix_x=40 → count=0, next emitted pixel pix_x=41. pop_stall=1 for 6 dots → no pops and pix_valid=0 throughout. bg_enable=0 → pix_idx=0 and pix_shade=bgp[1:0].
6. Reset mid-line: assert reset_n=0 at pix_x=80 → all outputs return to reset values next edge and no line_done occurs.

Source files
------------

// File: rtl/bg_pixel_shifter.sv
// Background pixel FIFO and shifter: buffers fetched BG/window pixels, drops the
// fine-scroll pixels at line start, palette-maps the rest and emits one per dot.
package ppu_pkg;
  typedef struct packed {
    logic       valid;
    logic [1:0] color;
  } ppu_pixel_t;
endpackage

// state   | meaning
// IDLE    | waiting for the first line_start, no pops
// DISCARD | popping and dropping SCX[2:0] pixels, X frozen
// SHIFT   | each pop emits a pixel and advances X
// DONE    | LINE_W pixels emitted, pushes still accepted
module bg_pixel_shifter
  import ppu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LINE_W = 160
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_dot_en,
  input  logic                   i_line_start,
  input  logic                   i_flush,
  input  logic                   i_pop_stall,
  input  logic [2:0]             i_scx_fine,
  input  logic [7:0]             i_bgp,
  input  logic                   i_bg_enable,
  input  logic                   i_push_en,
  input  ppu_pixel_t             i_push_px,
  output logic                   o_fifo_full,
  output logic                   o_fifo_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_pix_valid,
  output logic [1:0]             o_pix_idx,
  output logic [1:0]             o_pix_shade,
  output logic [7:0]             o_pix_x,
  output logic                   o_line_done,
  output logic                   o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  LAST_X   = 8'(LINE_W - 1);

  typedef enum logic [1:0] {IDLE, DISCARD, SHIFT, DONE} state_t;

  state_t        r_state;
  ppu_pixel_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_disc_cnt;
  logic [7:0]    r_x;
  logic          r_pix_valid, r_line_done, r_overflow;
  logic [1:0]    r_pix_idx, r_pix_shade;
  logic [7:0]    r_pix_x;

  logic          w_clear, w_full, w_push, w_pop;
  ppu_pixel_t    w_head;
  logic [1:0]    w_idx, w_shade;

  // line_start and flush both empty the FIFO and swallow any same-cycle push or pop
  assign w_clear = i_line_start | i_flush;
  assign w_full  = (r_count == FULL_CNT);
  assign w_push  = i_push_en && !w_full && !w_clear;
  assign w_pop   = i_dot_en && !i_pop_stall && (r_count != '0) && !w_clear &&
                   ((r_state == DISCARD) || (r_state == SHIFT));
  assign w_head  = r_mem[r_rd_ptr];
  assign w_idx   = i_bg_enable ? w_head.color : 2'd0;

  always_comb begin
    w_shade = i_bgp[1:0];
    case (w_idx)
      2'd0: w_shade = i_bgp[1:0];
      2'd1: w_shade = i_bgp[3:2];
      2'd2: w_shade = i_bgp[5:4];
      2'd3: w_shade = i_bgp[7:6];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_px;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_disc_cnt  <= '0;
      r_x         <= '0;
      r_pix_valid <= 1'b0;
      r_pix_idx   <= '0;
      r_pix_shade <= '0;
      r_pix_x     <= '0;
      r_line_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      r_line_done <= 1'b0;
      if (i_line_start) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_x        <= '0;
        r_disc_cnt <= i_scx_fine;
        r_state    <= (i_scx_fine != 3'd0) ? DISCARD : SHIFT;
      end else if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        if (r_state == DISCARD) r_state <= SHIFT;
      end else begin
        if (i_push_en && w_full) r_overflow <= 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_pop && r_state == DISCARD) begin
          r_disc_cnt <= r_disc_cnt - 1'b1;
          if (r_disc_cnt == 3'd1) r_state <= SHIFT;
        end else if (w_pop && r_state == SHIFT) begin
          r_pix_valid <= w_head.valid;
          r_pix_idx   <= w_idx;
          r_pix_shade <= w_shade;
          r_pix_x     <= r_x;
          if (r_x == LAST_X) begin
            r_line_done <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
      end
    end
  end

  assign o_fifo_full  = w_full;
  assign o_fifo_empty = (r_count == '0);
  assign o_count      = r_count;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_idx    = r_pix_idx;
  assign o_pix_shade  = r_pix_shade;
  assign o_pix_x      = r_pix_x;
  assign o_line_done  = r_line_done;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Bench for bg_pixel_shifter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bg_pixel_shifter;
  import ppu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, dot_en, line_start, flush, pop_stall, bg_enable, push_en;
  logic [2:0] scx_fine;
  logic [7:0] bgp;
  ppu_pixel_t push_px;
  logic fifo_full, fifo_empty, pix_valid, line_done, overflow;
  logic [4:0] count;
  logic [1:0] pix_idx, pix_shade;
  logic [7:0] pix_x;

  bg_pixel_shifter #(.DEPTH(16), .LINE_W(160)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_dot_en(dot_en), .i_line_start(line_start),
    .i_flush(flush), .i_pop_stall(pop_stall), .i_scx_fine(scx_fine), .i_bgp(bgp),
    .i_bg_enable(bg_enable), .i_push_en(push_en), .i_push_px(push_px),
    .o_fifo_full(fifo_full), .o_fifo_empty(fifo_empty), .o_count(count),
    .o_pix_valid(pix_valid), .o_pix_idx(pix_idx), .o_pix_shade(pix_shade),
    .o_pix_x(pix_x), .o_line_done(line_done), .o_overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a pixel queue, pixels still to drop, and the next screen X
  logic [1:0] mq[$];
  logic [1:0] m_c;
  int  m_disc = 0, m_x = 0, m_mode = 0;  // mode 0 no line yet, 1 in line, 2 line finished
  bit  m_ovf = 0, m_full = 0;
  bit  e_valid = 0, e_done = 0;
  int  e_idx = 0, e_shade = 0, e_x = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_disc = 0; m_x = 0; m_mode = 0; m_ovf = 0;
      e_valid = 0; e_done = 0; e_idx = 0; e_shade = 0; e_x = 0;
    end else begin
      e_valid = 0;
      e_done  = 0;
      if (line_start) begin
        mq.delete();
        m_x = 0; m_disc = int'(scx_fine); m_mode = 1;
      end else if (flush) begin
        mq.delete();
        m_disc = 0;
      end else begin
        m_full = (mq.size() == 16);
        if (push_en && m_full) m_ovf = 1;
        if (m_mode == 1 && dot_en && !pop_stall && mq.size() > 0) begin
          m_c = mq.pop_front();
          if (m_disc > 0) m_disc--;
          else begin
            e_valid = 1;
            e_idx   = bg_enable ? int'(m_c) : 0;
            e_shade = (int'(bgp) >> (2 * e_idx)) & 3;
            e_x     = m_x;
            if (m_x == 159) begin e_done = 1; m_mode = 2; end
            else m_x++;
          end
        end
        if (push_en && !m_full) mq.push_back(push_px.color);
      end
    end
  end

  bit chk_en = 0;
  int lg_idx[$], lg_x[$], lg_shade[$];
  int n_emit = 0, done_cnt = 0, done_x = -1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("fifo_full", 32'(fifo_full), 32'(mq.size() == 16));
      check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("pix_valid", 32'(pix_valid), 32'(e_valid));
      check("line_done", 32'(line_done), 32'(e_done));
      check("pix_idx", 32'(pix_idx), 32'(e_idx));
      check("pix_shade", 32'(pix_shade), 32'(e_shade));
      check("pix_x", 32'(pix_x), 32'(e_x));
      if (pix_valid === 1'b1) begin
        lg_idx.push_back(int'(pix_idx));
        lg_x.push_back(int'(pix_x));
        lg_shade.push_back(int'(pix_shade));
        n_emit++;
      end
      if (line_done === 1'b1) begin
        done_cnt++;
        done_x = int'(pix_x);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_log();
    lg_idx.delete(); lg_x.delete(); lg_shade.delete();
    n_emit = 0; done_cnt = 0; done_x = -1;
  endtask

  function automatic int lg_at(input int which, input int i);
    if (which == 0) return (i < lg_idx.size())   ? lg_idx[i]   : 99;
    if (which == 1) return (i < lg_x.size())     ? lg_x[i]     : 999;
    return (i < lg_shade.size()) ? lg_shade[i] : 99;
  endfunction

  // Push one pixel per dot until pixel target_x is on the outputs; bounded
  task automatic run_to_x(input int target_x, input string name);
    bit found = 0;
    for (int i = 0; i < 250 && !found; i++) begin
      push_en = 1'b1;
      push_px.color = 2'(i % 4);
      step();
      if (pix_valid === 1'b1 && int'(pix_x) == target_x) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  int exp2_idx[5] = '{3, 0, 1, 2, 3};

  initial begin
    reset_n = 1'b0; dot_en = 1'b0; line_start = 1'b0; flush = 1'b0; pop_stall = 1'b0;
    scx_fine = 3'd0; bgp = 8'hE4; bg_enable = 1'b1; push_en = 1'b1;
    push_px = '{valid: 1'b1, color: 2'd2};
    step(); step();
    chk_en = 1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // IDLE: pushes accumulate, nothing is shifted out
    reset_n = 1'b1; dot_en = 1'b1;
    repeat (3) step();
    check("idle_count", 32'(count), 32'd3);
    check("idle_emits", 32'(n_emit), 32'd0);
    push_en = 1'b0;

    // Fine scroll of 3 with an identity palette
    line_start = 1'b1; scx_fine = 3'd3;
    clear_log();
    step();
    line_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_en = 1'b1; push_px.color = 2'(i % 4);
      step();
    end
    push_en = 1'b0;
    repeat (6) step();
    check("scroll_emits", 32'(n_emit), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("scroll_idx", 32'(lg_at(0, i)), 32'(exp2_idx[i]));
      check("scroll_x", 32'(lg_at(1, i)), 32'(i));
      check("scroll_shade", 32'(lg_at(2, i)), 32'(exp2_idx[i]));
    end

    // Simultaneous push/pop, then fill and overflow
    dot_en = 1'b0; push_px.color = 2'd1;
    repeat (5) begin push_en = 1'b1; step(); end
    check("pre_pp_count", 32'(count), 32'd5);
    dot_en = 1'b1;
    step();
    check("pushpop_count", 32'(count), 32'd5);
    dot_en = 1'b0;
    repeat (11) step();
    check("fill_full", 32'(fifo_full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    dot_en = 1'b1;
    step();
    check("full_pop_count", 32'(count), 32'd15);
    push_en = 1'b0;
    repeat (20) step();

    // Full line with no scroll: 168 pixels fed, 160 shifted out
    line_start = 1'b1; scx_fine = 3'd0;
    step();
    line_start = 1'b0;
    clear_log();
    for (int i = 0; i < 168; i++) begin
      push_en = 1'b1; push_px.color = 2'(i % 4);
      step();
    end
    push_en = 1'b0;
    repeat (10) step();
    check("line_done_cnt", 32'(done_cnt), 32'd1);
    check("line_done_x", 32'(done_x), 32'd159);
    check("line_emits", 32'(n_emit), 32'd160);
    check("leftover_count", 32'(count), 32'd8);

    // Flush mid-line, stall, BG disabled
    bgp = 8'h1B;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    run_to_x(40, "reach_x40");
    flush = 1'b1; push_en = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    clear_log();
    push_px.color = 2'd1;
    repeat (3) step();
    check("flush_next_x", 32'(lg_at(1, 0)), 32'd41);
    check("flush_next_shade", 32'(lg_at(2, 0)), 32'd2);
    pop_stall = 1'b1;
    repeat (6) begin
      step();
      check("stall_valid", 32'(pix_valid), 32'd0);
    end
    pop_stall = 1'b0; bg_enable = 1'b0;
    clear_log();
    repeat (3) step();
    check("bgoff_idx", 32'(lg_at(0, 0)), 32'd0);
    check("bgoff_shade", 32'(lg_at(2, 0)), 32'd3);
    bg_enable = 1'b1;

    // Reset in the middle of a line
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    clear_log();
    run_to_x(80, "reach_x80");
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_x", 32'(pix_x), 32'd0);
    check("mid_rst_idx", 32'(pix_idx), 32'd0);
    check("mid_rst_shade", 32'(pix_shade), 32'd0);
    check("mid_rst_done", 32'(line_done), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    clear_log();
    repeat (10) step();
    check("post_rst_emits", 32'(n_emit), 32'd0);
    check("post_rst_done", 32'(done_cnt), 32'd0);
    check("post_rst_count", 32'(count), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
